// File: rtl/fifo_ctrl_mem_if.sv
// Push/pop handshake, thresholds and status bundle for fifo_ctrl_mem.
// No latency of its own; it only groups wires.
// No backpressure inside; the full/empty/almost flags travel back to the producer and consumer.
interface fifo_ctrl_mem_if #(
    parameter int DATA_SIZE = 12,
    parameter int ADDR_SIZE = 3
);
    logic [DATA_SIZE-1:0] data_in;
    logic                 push;
    logic                 pop;
    logic                 clear_err;
    logic [ADDR_SIZE:0]   thr_high;
    logic [ADDR_SIZE:0]   thr_low;
    logic [DATA_SIZE-1:0] data_out;
    logic                 valid_out;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [ADDR_SIZE:0]   count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output data_in, push, pop, clear_err, thr_high, thr_low,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  data_in, push, pop, clear_err, thr_high, thr_low,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl_mem.sv
// Synchronous FIFO with storage, pointers, occupancy, thresholds and sticky errors; FIFO_FWFT_EN selects fall-through read.
// Latency: 1 cycle from pop to data_out (registered read), or head shown combinationally in the FWFT build.
// Backpressure: a push while full is refused unless a pop is accepted in the same cycle; refused ops set sticky flags.
module fifo_ctrl_mem #(
    parameter int DATA_SIZE = 12,
    parameter int ADDR_SIZE = 3
) (
    input  logic           clk,
    input  logic           reset_L,
    fifo_ctrl_mem_if.slave bus
);
    localparam int                 DEPTH   = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE + 1)'(DEPTH);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE:0]   count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 full_w, empty_w, push_ok, pop_ok;

    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);
    assign pop_ok  = bus.pop && !empty_w;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
    assign push_ok = bus.push && (!full_w || pop_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q && !bus.clear_err;
        underflow_d = underflow_q && !bus.clear_err;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (bus.push && !push_ok) overflow_d  = 1'b1;
        if (bus.pop && !pop_ok)   underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.data_in;
    end

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= bus.thr_high);
    assign bus.almost_empty = (count_q <= bus.thr_low);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

`ifdef FIFO_FWFT_EN
    assign bus.data_out  = empty_w ? '0 : mem_q[rd_ptr_q];
    assign bus.valid_out = !empty_w;
`else
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;
    logic                 valid_out_q;

    // Reads the old head before a same-edge write can overwrite that slot.
    assign data_out_d = pop_ok ? mem_q[rd_ptr_q] : data_out_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            valid_out_q <= pop_ok;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
`endif
endmodule

// File: tb/tb_fifo_ctrl_mem.sv
// Directed, table-driven bench for fifo_ctrl_mem at DATA_SIZE=12, ADDR_SIZE=3 (depth 8).
module tb_fifo_ctrl_mem;
    logic clk;
    logic reset_L;
    int   checks = 0;
    int   errors = 0;

    fifo_ctrl_mem_if #(.DATA_SIZE(12), .ADDR_SIZE(3)) bus ();

    fifo_ctrl_mem #(.DATA_SIZE(12), .ADDR_SIZE(3)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        push, pop, clr;
        logic [11:0] din;
        logic [3:0]  thh, thl;
        logic [3:0]  cnt;
        logic        full, empty, af, ae, vld;
        logic [11:0] dout;
        logic        ovf, unf;
    } vec_t;

    vec_t       vq[$];
    logic [3:0] th_h = 4'd6;
    logic [3:0] th_l = 4'd2;

    function automatic void add(logic push, logic pop, logic clr, logic [11:0] din,
                                logic [3:0] cnt, logic vld, logic [11:0] dout,
                                logic ovf, logic unf);
        vec_t v;
        v.push = push; v.pop = pop; v.clr = clr; v.din = din;
        v.thh = th_h; v.thl = th_l;
        v.cnt = cnt;
        v.full  = (cnt == 4'd8);
        v.empty = (cnt == 4'd0);
        v.af    = (cnt >= th_h);
        v.ae    = (cnt <= th_l);
        v.vld = vld; v.dout = dout; v.ovf = ovf; v.unf = unf;
        vq.push_back(v);
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d] actual=%0h required=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(logic push, logic pop, logic clr, logic [11:0] din);
        bus.push = push; bus.pop = pop; bus.clear_err = clr; bus.data_in = din;
    endtask

    task automatic check_vec(vec_t v, int i);
        chk("count", i, 32'(bus.count), 32'(v.cnt));
        chk("full", i, 32'(bus.full), 32'(v.full));
        chk("empty", i, 32'(bus.empty), 32'(v.empty));
        chk("almost_full", i, 32'(bus.almost_full), 32'(v.af));
        chk("almost_empty", i, 32'(bus.almost_empty), 32'(v.ae));
        chk("overflow", i, 32'(bus.overflow), 32'(v.ovf));
        chk("underflow", i, 32'(bus.underflow), 32'(v.unf));
`ifndef FIFO_FWFT_EN
        chk("valid_out", i, 32'(bus.valid_out), 32'(v.vld));
        chk("data_out", i, 32'(bus.data_out), 32'(v.dout));
`endif
    endtask

    initial begin
        reset_L = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 12'h000);
        bus.thr_high = 4'd0;
        bus.thr_low  = 4'd2;

        // Fill then drain in order.
        for (int k = 1; k <= 8; k++) add(1, 0, 0, 12'(k), 4'(k), 0, 12'h000, 0, 0);
        for (int j = 1; j <= 8; j++) add(0, 1, 0, 12'h000, 4'(8 - j), 1, 12'(j), 0, 0);
        add(0, 0, 0, 12'h000, 4'd0, 0, 12'h008, 0, 0);
        add(0, 1, 0, 12'h000, 4'd0, 0, 12'h008, 0, 1);
        add(1, 1, 0, 12'h055, 4'd1, 0, 12'h008, 0, 1);
        add(0, 0, 1, 12'h000, 4'd1, 0, 12'h008, 0, 0);
        add(0, 1, 0, 12'h000, 4'd0, 1, 12'h055, 0, 0);
        // Five in, five out, then six more to cross the pointer wrap.
        for (int k = 1; k <= 5; k++) add(1, 0, 0, 12'(12'h100 + k), 4'(k), 0, 12'h055, 0, 0);
        for (int j = 1; j <= 5; j++) add(0, 1, 0, 12'h000, 4'(5 - j), 1, 12'(12'h100 + j), 0, 0);
        for (int k = 1; k <= 6; k++) add(1, 0, 0, 12'(12'hA00 + k), 4'(k), 0, 12'h105, 0, 0);
        for (int j = 1; j <= 6; j++) add(0, 1, 0, 12'h000, 4'(6 - j), 1, 12'(12'hA00 + j), 0, 0);
        // Full: simultaneous push/pop, refused push, threshold change.
        for (int k = 1; k <= 8; k++) add(1, 0, 0, 12'(12'h200 + k), 4'(k), 0, 12'hA06, 0, 0);
        add(1, 1, 0, 12'h0FF, 4'd8, 1, 12'h201, 0, 0);
        add(1, 0, 0, 12'h333, 4'd8, 0, 12'h201, 1, 0);
        th_h = 4'd8; th_l = 4'd8;
        add(0, 0, 0, 12'h000, 4'd8, 0, 12'h201, 1, 0);
        th_h = 4'd6; th_l = 4'd2;
        for (int j = 1; j <= 7; j++) add(0, 1, 0, 12'h000, 4'(8 - j), 1, 12'(12'h201 + j), 1, 0);
        add(0, 1, 0, 12'h000, 4'd0, 1, 12'h0FF, 1, 0);
        add(0, 1, 0, 12'h000, 4'd0, 0, 12'h0FF, 1, 1);
        add(0, 0, 1, 12'h000, 4'd0, 0, 12'h0FF, 0, 0);
        add(0, 1, 1, 12'h000, 4'd0, 0, 12'h0FF, 0, 1);
        th_h = 4'd0; th_l = 4'd0;
        add(0, 0, 1, 12'h000, 4'd0, 0, 12'h0FF, 0, 0);

        // Reset state, with thr_high=0 so almost_full must be high.
        #12;
        chk("rst_count", 0, 32'(bus.count), 32'd0);
        chk("rst_empty", 0, 32'(bus.empty), 32'd1);
        chk("rst_full", 0, 32'(bus.full), 32'd0);
        chk("rst_af_thr0", 0, 32'(bus.almost_full), 32'd1);
        chk("rst_ae", 0, 32'(bus.almost_empty), 32'd1);
        @(negedge clk);
        reset_L = 1'b1;
        bus.thr_high = 4'd6;
        @(posedge clk); #1;
        chk("rst_valid", 1, 32'(bus.valid_out), 32'd0);
        chk("rst_dout", 1, 32'(bus.data_out), 32'd0);
        chk("rst_ovf", 1, 32'(bus.overflow), 32'd0);
        chk("rst_unf", 1, 32'(bus.underflow), 32'd0);
        chk("rst_af", 1, 32'(bus.almost_full), 32'd0);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].push, vq[i].pop, vq[i].clr, vq[i].din);
            bus.thr_high = vq[i].thh;
            bus.thr_low  = vq[i].thl;
            @(posedge clk); #1;
            check_vec(vq[i], i);
        end

        // Reset in mid-operation drops content at once; first pop after release underflows.
        @(negedge clk);
        bus.thr_high = 4'd6; bus.thr_low = 4'd2;
        drive(1'b1, 1'b0, 1'b0, 12'h777);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 12'h000);
        chk("mid_cnt_before", 0, 32'(bus.count), 32'd1);
        #2 reset_L = 1'b0;
        #1;
        chk("mid_cnt_async", 0, 32'(bus.count), 32'd0);
        chk("mid_empty_async", 0, 32'(bus.empty), 32'd1);
        @(negedge clk);
        reset_L = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 12'h000);
        @(posedge clk); #1;
        chk("mid_unf", 0, 32'(bus.underflow), 32'd1);
        chk("mid_valid", 0, 32'(bus.valid_out), 32'd0);
        chk("mid_dout", 0, 32'(bus.data_out), 32'd0);

`ifdef FIFO_FWFT_EN
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 12'h123);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 12'h000);
        chk("fwft_valid", 0, 32'(bus.valid_out), 32'd1);
        chk("fwft_dout", 0, 32'(bus.data_out), 32'h123);
        @(posedge clk); #1;
        chk("fwft_hold", 0, 32'(bus.data_out), 32'h123);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 12'h000);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 12'h000);
        chk("fwft_empty", 0, 32'(bus.empty), 32'd1);
        chk("fwft_dout0", 0, 32'(bus.data_out), 32'd0);
        chk("fwft_valid0", 0, 32'(bus.valid_out), 32'd0);
`endif

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 12'h000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_ctrl_mem.md
# fifo_ctrl_mem

Parametrised synchronous FIFO that integrates storage, read/write pointers, occupancy counter, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the next-generation FIFO building block: upstream logic pushes words, and downstream logic pops them with a registered read or, optionally, a first-word-fall-through read. It replaces the bare memory-plus-external-pointer arrangement, so no pointer logic is needed outside the block.

## Interface
Parameters:
- DATA_SIZE, 12, word width in bits
- ADDR_SIZE, 3, pointer width; DEPTH = 2**ADDR_SIZE entries (default 8)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset_L  in  1  asynchronous, active-low reset
- data_in  in  DATA_SIZE  write data
- push  in  1  write request
- pop  in  1  read request
- clear_err  in  1  synchronous clear of the sticky error flags
- thr_high  in  ADDR_SIZE+1  almost-full threshold, range 0..DEPTH
- thr_low  in  ADDR_SIZE+1  almost-empty threshold, range 0..DEPTH
- data_out  out  DATA_SIZE  read data
- valid_out  out  1  data_out carries a popped/head word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= thr_high
- almost_empty  out  1  count <= thr_low
- count  out  ADDR_SIZE+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky; a push was refused
- underflow  out  1  sticky; a pop was refused

## Operation
- Storage is DEPTH x DATA_SIZE. The array is not reset, so its contents are undefined until written.
- wr_ptr and rd_ptr are ADDR_SIZE bits wide and wrap modulo DEPTH (7 -> 0 at default). count is a separate register of ADDR_SIZE+1 bits.
- pop_ok = pop && !empty.
- push_ok = push && (!full || pop_ok). A push on a full FIFO is accepted when a pop is accepted in the same cycle.
- On push_ok: mem[wr_ptr] <= data_in, and wr_ptr increments.
- On pop_ok: rd_ptr increments.
- count update: push_ok only +1; pop_ok only -1; both or neither leaves count unchanged.
- Push and pop on an empty FIFO: the pop is refused and underflow is set. The push is accepted, so count goes 0 -> 1.
- overflow is set when push && !push_ok. underflow is set when pop && !pop_ok.
- Both error flags hold until reset or clear_err. If clear_err coincides with a new error, the flag stays set (set wins).
- Refused operations do not change the pointers, count or memory.
- full, empty, almost_full and almost_empty are combinational compares of the registered count against the current thr_high/thr_low.
- Thresholds are quasi-static. A threshold change takes effect on the flags in the same cycle.

## Timing
- Reset (asynchronous assert, synchronous release):
  - wr_ptr, rd_ptr and count = 0; data_out = 0; valid_out = 0; overflow = underflow = 0.
  - Resulting flags: empty = 1, full = 0, almost_empty = 1, almost_full = (thr_high == 0).
- Reset asserted mid-operation discards all content immediately. The first pop after release underflows.
- Default (registered read):
  - On pop_ok at edge N: data_out <= mem[rd_ptr] and valid_out <= 1, both visible after edge N. Read latency is 1 cycle.
  - Without pop_ok: valid_out <= 0, and data_out holds its last value.
- Simultaneous push and pop while full: the read captures the old word before the write overwrites that slot.
- Flags and count reflect the edge-N update after edge N.

## Configuration
- FIFO_FWFT_EN defined (first-word fall-through):
  - data_out = mem[rd_ptr] combinationally when !empty, otherwise 0.
  - valid_out = !empty.
  - pop acknowledges the current head; the next word appears after the edge.
  - The first pushed word is visible the cycle after its push edge.
- FIFO_FWFT_EN undefined: the registered-read behaviour in Timing applies.
- All other behaviour is identical in both configurations.

## Test plan
- Reset then idle: after reset_L=0 -> 1, outputs are count=0, empty=1, full=0, valid_out=0, data_out=0, overflow=underflow=0.
- Fill and drain (thr_high=6, thr_low=2): push 0x001..0x008 -> full=1 after the 8th push, and almost_full asserts once count=6. Then pop 8 times -> data_out 0x001..0x008 in order, each 1 cycle after its pop, then empty=1.
- Wrap-around: push 5, pop 5, then push 0xA01..0xA06 and pop 6 -> order is preserved across the 7 -> 0 pointer wrap, and count returns to 0.
- Full with simultaneous push/pop of 0x0FF: count stays 8, overflow stays 0, the popped word is the oldest entry, and 0x0FF is read last.
- Errors: pop while empty -> underflow=1; push while full with no pop -> overflow=1 and count stays 8. clear_err for one cycle -> both flags = 0. clear_err together with a new refused pop -> underflow stays 1.
- FWFT build: a single push of 0x123 -> valid_out=1 and data_out=0x123 the next cycle with no pop issued; a pop then gives empty=1 and data_out=0.
